// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder:
// operand width, op encoding and state encodings.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_ITER,
    MD_FIX
  } md_phase_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring
// on magnitudes), one step per clock, sign fix in the final phase.
import alu_pkg::*;

module alu_seq_muldiv (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                is_div,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                last,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                div_by_zero
);

  md_phase_t phase, phase_n;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc, acc_n, m;
  logic [DATA_W-1:0] q, q_n;
  logic              q1, q1_n;
  logic              div_q, neg_a, neg_b, dz;
  logic [DATA_W-1:0] sa;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   bsum, shifted;
  logic [DATA_W+1:0] diff;
  logic [DATA_W-1:0] quo, rem;

  assign a_mag = a[DATA_W-1] ? -a : a;
  assign b_mag = b[DATA_W-1] ? -b : b;

  always_comb begin
    acc_n   = acc;
    q_n     = q;
    q1_n    = q1;
    bsum    = acc;
    shifted = '0;
    diff    = '0;
    if (div_q) begin
      shifted = {acc[DATA_W-1:0], q[DATA_W-1]};
      diff    = {1'b0, shifted} - {1'b0, m};
      if (!diff[DATA_W+1]) begin
        acc_n = diff[DATA_W:0];
        q_n   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        q_n   = {q[DATA_W-2:0], 1'b0};
      end
    end else begin
      case ({q[0], q1})
        2'b01:   bsum = acc + m;
        2'b10:   bsum = acc - m;
        default: bsum = acc;
      endcase
      acc_n = {bsum[DATA_W], bsum[DATA_W:1]};
      q_n   = {bsum[0], q[DATA_W-1:1]};
      q1_n  = q[0];
    end
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    quo = (neg_a ^ neg_b) ? -q : q;
    rem = neg_a ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    if (!div_q)
      result = {acc[DATA_W-1:0], q};
    else if (dz)
      result = {sa, {DATA_W{1'b1}}};
    else
      result = {rem, quo};
  end

  always_comb begin
    phase_n = phase;
    case (phase)
      MD_IDLE: if (start) phase_n = MD_ITER;
      MD_ITER: if (last) phase_n = MD_FIX;
      MD_FIX:  phase_n = MD_IDLE;
      default: phase_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) phase <= MD_IDLE;
    else        phase <= phase_n;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt   <= '0;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q1    <= 1'b0;
      div_q <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dz    <= 1'b0;
      sa    <= '0;
    end else begin
      case (phase)
        MD_IDLE: if (start) begin
          div_q <= is_div;
          sa    <= a;
          neg_a <= a[DATA_W-1];
          neg_b <= b[DATA_W-1];
          dz    <= (b == '0);
          cnt   <= '0;
          acc   <= '0;
          q1    <= 1'b0;
          if (is_div) begin
            q <= a_mag;
            m <= {1'b0, b_mag};
          end else begin
            q <= b;
            m <= {a[DATA_W-1], a};
          end
        end
        MD_ITER: begin
          acc <= acc_n;
          q   <= q_n;
          q1  <= q1_n;
          cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign last = (phase == MD_ITER) && (cnt == CNT_W'(DATA_W - 1));
  assign done = (phase == MD_FIX);
  assign div_by_zero = div_q && dz;

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked multi-cycle ALU: single-cycle ops computed here,
// MUL/DIV delegated to the iterative muldiv datapath.
import alu_pkg::*;

module alu_seq_responder (
  input  logic                clock,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [3:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] result,
  output logic                div_by_zero,
  output logic                illegal_op
);

  state_t state, state_n;

  logic                accept, is_md;
  logic                md_last, md_done, md_dz;
  logic [2*DATA_W-1:0] md_result;
  logic [DATA_W-1:0]   simple;
  logic                bad;
  logic [4:0]          sh;
  logic [2*DATA_W-1:0] rot_r, rot_l;

  logic [2*DATA_W-1:0] result_q;
  logic                dz_q, ill_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_md     = (op == OP_MUL) || (op == OP_DIV);

  alu_seq_muldiv u_muldiv (
    .clock       (clock),
    .clear       (clear),
    .start       (accept && is_md),
    .is_div      (op == OP_DIV),
    .a           (a),
    .b           (b),
    .last        (md_last),
    .done        (md_done),
    .result      (md_result),
    .div_by_zero (md_dz)
  );

  always_comb begin
    simple = '0;
    bad    = 1'b0;
    sh     = b[4:0];
    rot_r  = {a, a} >> sh;
    rot_l  = {a, a} << sh;
    case (op)
      OP_AND:  simple = a & b;
      OP_OR:   simple = a | b;
      OP_ADD:  simple = a + b;
      OP_SUB:  simple = a - b;
      OP_SHR:  simple = a >> sh;
      OP_SHRA: simple = $signed(a) >>> sh;
      OP_SHL:  simple = a << sh;
      OP_ROR:  simple = rot_r[DATA_W-1:0];
      OP_ROL:  simple = rot_l[2*DATA_W-1:DATA_W];
      OP_NEG:  simple = -a;
      OP_NOT:  simple = ~a;
      OP_MUL,
      OP_DIV:  simple = '0;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = is_md ? ITER : DONE;
      ITER: if (md_last) state_n = FIX;
      FIX:  if (md_done) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      result_q <= '0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (accept && !is_md) begin
      result_q <= {{DATA_W{1'b0}}, simple};
      dz_q     <= 1'b0;
      ill_q    <= bad;
    end else if (state == FIX && md_done) begin
      result_q <= md_result;
      dz_q     <= md_dz;
      ill_q    <= 1'b0;
    end
  end

  assign result      = result_q;
  assign div_by_zero = dz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Table-driven bench with a scoreboard queue for alu_seq_responder.
import alu_pkg::*;

module tb_alu_seq_responder;

  localparam int W = DATA_W;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [3:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic           div_by_zero;
  logic           illegal_op;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           dz;
    logic           ill;
    int             lat;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    logic           ill;
    int             lat;
    int             t0;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  alu_seq_responder dut (
    .clock       (clock),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edges++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(logic [3:0] o, logic [W-1:0] x,
                              logic [W-1:0] y, logic [2*W-1:0] r,
                              logic z, logic il, int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r;
    v.dz = z; v.ill = il; v.lat = l;
    tbl.push_back(v);
  endfunction

  task automatic drive(vec_t v);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = v.op;
    a  = v.a;
    b  = v.b;
    @(posedge clock);
    #1;
    e.res = v.res; e.dz = v.dz; e.ill = v.ill;
    e.lat = v.lat; e.t0 = edges;
    sb.push_back(e);
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 4'($urandom);
  endtask

  task automatic collect(string name);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got output expected none", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_result"}, result, e.res);
    check({name, "_dz"}, 64'(div_by_zero), 64'(e.dz));
    check({name, "_ill"}, 64'(illegal_op), 64'(e.ill));
    check({name, "_lat"}, 64'(edges - e.t0 + 1), 64'(e.lat));
  endtask

  task automatic handshake_done(string name);
    @(posedge clock);
    @(negedge clock);
    check({name, "_ready_after"}, 64'(in_ready), 64'd1);
    check({name, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int hits;
    vec_t v;

    add(OP_ADD, 32'd12, 32'd28, 64'd40, 0, 0, 1);
    add(OP_MUL, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0, 34);
    add(OP_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 64'd12, 0, 0, 34);
    add(OP_DIV, 32'd24, 32'd12, 64'd2, 0, 0, 34);
    add(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 34);
    add(OP_DIV, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 0, 34);
    add(OP_ROR, 32'hFFFF_FFFC, 32'd1, 64'h7FFF_FFFE, 0, 0, 1);
    add(OP_SHRA, 32'h8000_0000, 32'd4, 64'hF800_0000, 0, 0, 1);
    add(OP_ROL, 32'd4, 32'd0, 64'd4, 0, 0, 1);
    add(4'd13, 32'hDEAD_BEEF, 32'd7, 64'd0, 0, 1, 1);
    add(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, 34);
    add(OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0, 34);
    add(OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, 34);
    add(OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0, 0, 34);
    add(OP_SUB, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE, 0, 0, 1);
    add(OP_SHL, 32'd1, 32'd31, 64'h8000_0000, 0, 0, 1);
    add(OP_SHL, 32'd3, 32'h21, 64'd6, 0, 0, 1);
    add(OP_SHR, 32'h8000_0000, 32'd31, 64'd1, 0, 0, 1);
    add(OP_NEG, 32'd1, 32'd0, 64'h0000_0000_FFFF_FFFF, 0, 0, 1);
    add(OP_AND, 32'hF0F0, 32'hFF00, 64'hF000, 0, 0, 1);
    add(OP_OR, 32'hF0F0, 32'h0F0F, 64'hFFFF, 0, 0, 1);
    add(4'd15, 32'd1, 32'd1, 64'd0, 0, 1, 1);

    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_ill", 64'(illegal_op), 64'd0);
    clear = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      collect($sformatf("vec%0d", i));
      handshake_done($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    v.op = OP_NOT; v.a = 32'd4; v.b = 32'd0;
    v.res = 64'hFFFF_FFFB; v.dz = 0; v.ill = 0; v.lat = 1;
    drive(v);
    collect("bp");
    in_valid = 1'b1;
    op = OP_ADD;
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_hold", result, 64'hFFFF_FFFB);
      check("bp_busy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    handshake_done("bp");
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (out_valid) hits++;
    end
    check("bp_no_extra", 64'(hits), 64'd0);

    // Reset in the middle of a multiply discards it.
    v.op = OP_MUL; v.a = 32'hFFFF_FFFD; v.b = 32'd4;
    v.res = 64'hFFFF_FFFF_FFFF_FFF4; v.lat = 34;
    drive(v);
    repeat (10) @(negedge clock);
    clear = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_result", result, 64'd0);
    sb.delete();
    @(negedge clock);
    clear = 1'b1;
    v.op = OP_ADD; v.a = 32'd1; v.b = 32'd1;
    v.res = 64'd2; v.dz = 0; v.ill = 0; v.lat = 1;
    drive(v);
    collect("post_rst");
    handshake_done("post_rst");
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) hits++;
    end
    check("post_rst_stale", 64'(hits), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
